soc_bus_fabric: RTL
===================

# soc_bus_fabric

Parametrised address decoder, read-data mux and wait-state controller between the FemtoRV32 memory port and N slave devices (RAM plus memory-mapped peripherals). It replaces the combinational chip-select/read-mux logic in the SoC top. It adds registered read data, per-slave busy handshakes, access timeout, and sticky error capture for unmapped or hung accesses.

## Interface
Parameters:
- N_SLAVES, 8, slave count; slave 0 is the default target (RAM).
- BASE_REGION, 16'h0040, mem_addr[31:16] value mapped to slave 1.
- RESERVED_SPAN, 16, regions BASE_REGION..BASE_REGION+RESERVED_SPAN-1 form the peripheral window; N_SLAVES-1 must be ≤ RESERVED_SPAN.
- TIMEOUT_CYCLES, 255, max wait cycles before abort (1..65535).
- ERR_DATA, 32'h6666_6666, read data returned on error.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- mem_addr  in  32  CPU address.
- mem_wdata  in  32  CPU write data, passed through to slaves unchanged.
- mem_wmask  in  4  CPU byte write mask; nonzero = write request.
- mem_rstrb  in  1  CPU read strobe, one-cycle pulse.
- mem_rdata  out  32  registered read data.
- mem_rbusy  out  1  read in progress.
- mem_wbusy  out  1  write in progress.
- s_cs  out  N_SLAVES  one-hot decoded select, combinational from mem_addr.
- s_rd  out  N_SLAVES  read pulse to selected slave.
- s_wr  out  N_SLAVES  write pulse to selected slave.
- s_wmask  out  4*N_SLAVES  mem_wmask gated per slave (slave i at [4i+3:4i]).
- s_rdata  in  32*N_SLAVES  slave read data (slave i at [32i+31:32i]).
- s_busy  in  N_SLAVES  slave not ready; sampled only for the slave latched at request.
- err_clr  in  1  clears bus_err/err_code.
- bus_err  out  1  sticky error flag.
- err_code  out  2  01 unmapped, 10 timeout, 00 none.
- err_addr  out  32  address of first uncleared error.
- err_count  out  8  saturating error counter; cleared only by reset.

## Operation
- Decode on r = mem_addr[31:16]:
  - r = BASE_REGION+k, 0 ≤ k < N_SLAVES-1 → slave k+1.
  - r in BASE_REGION+N_SLAVES-1 .. BASE_REGION+RESERVED_SPAN-1 → unmapped; s_cs all zero.
  - Any other r → slave 0.
- FSM states: IDLE, RWAIT, WWAIT.
- IDLE: a request is accepted in the cycle it is presented.
  - If mem_wmask≠0: pulse s_wr[sel] and s_wmask[sel] for one cycle; latch sel and addr; go to WWAIT.
  - Else if mem_rstrb: pulse s_rd[sel] for one cycle; latch sel and addr; go to RWAIT.
  - A write and a read strobe in the same cycle: the write wins and the read is dropped.
- RWAIT, each cycle:
  - Unmapped: mem_rdata←ERR_DATA; log error 01; go to IDLE.
  - s_busy[sel_q]=0: mem_rdata←s_rdata[sel_q]; go to IDLE.
  - Wait counter = TIMEOUT_CYCLES: mem_rdata←ERR_DATA; log error 10; go to IDLE.
  - Otherwise increment the counter.
- WWAIT: same as RWAIT without updating mem_rdata.
- Requests arriving in RWAIT/WWAIT are ignored; no strobes are forwarded.
- Error logging:
  - err_count increments and saturates at 255.
  - If bus_err=0: set bus_err, err_code, err_addr←addr_q.
  - If bus_err=1: keep the first error's code and address.
  - err_clr and a new error in the same cycle: the new error is captured.

## Timing
- Reset values: mem_rdata=0, mem_rbusy=0, mem_wbusy=0, bus_err=0, err_code=0, err_addr=0, err_count=0, FSM=IDLE, counter=0.
- s_cs, s_rd, s_wr, s_wmask are combinational in the request cycle (cycle 0).
- mem_rbusy = (state==RWAIT) and mem_wbusy = (state==WWAIT); both registered.
- Zero-wait read: strobe in cycle 0; rbusy=1 in cycle 1; mem_rdata valid with rbusy=0 in cycle 2.
- Each busy cycle from the slave adds one cycle.
- Timeout abort: the FSM leaves the wait state after TIMEOUT_CYCLES+1 wait cycles.
- mem_rdata holds its value until the next completed read.
- Reset asserted mid-access: the FSM returns to IDLE immediately and no completion is produced.

## Test plan
- Read from 0x0042_0010 with slave 3 s_rdata=0x1234_5678, s_busy=0 → s_rd[3] pulses in cycle 0; mem_rdata=0x1234_5678 in cycle 2; bus_err=0.
- Write 0xAB, wmask=0001 to 0x0000_0100 with slave 0 busy for 3 cycles → s_wr[0] is a single pulse; s_wmask[3:0]=0001; mem_wbusy high for 4 cycles.
- Read from 0x0049_0000 → no s_rd; mem_rdata=0x6666_6666; bus_err=1; err_code=01; err_addr=0x0049_0000; err_count=1.
- Slave 2 held busy with TIMEOUT_CYCLES=4 → abort after 5 wait cycles; err_code=10; a second error leaves err_addr unchanged and sets err_count=2.
- mem_rstrb and mem_wmask=1111 in the same cycle → only s_wr fires; FSM enters WWAIT; mem_rdata is unchanged.
- Assert reset during RWAIT → all outputs return to reset values asynchronously; the next read completes normally.

Source files
------------

// File: rtl/soc_bus_fabric.sv
// Address decoder, read-data mux and wait-state controller between the CPU
// memory port and N slaves, with a timeout and sticky error capture.
module soc_bus_fabric #(
  parameter int          N_SLAVES       = 8,
  parameter logic [15:0] BASE_REGION    = 16'h0040,
  parameter int          RESERVED_SPAN  = 16,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = 32'h6666_6666
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             mem_addr,
  input  logic [31:0]             mem_wdata,
  input  logic [3:0]              mem_wmask,
  input  logic                    mem_rstrb,
  output logic [31:0]             mem_rdata,
  output logic                    mem_rbusy,
  output logic                    mem_wbusy,
  output logic [N_SLAVES-1:0]     s_cs,
  output logic [N_SLAVES-1:0]     s_rd,
  output logic [N_SLAVES-1:0]     s_wr,
  output logic [4*N_SLAVES-1:0]   s_wmask,
  input  logic [32*N_SLAVES-1:0]  s_rdata,
  input  logic [N_SLAVES-1:0]     s_busy,
  input  logic                    err_clr,
  output logic                    bus_err,
  output logic [1:0]              err_code,
  output logic [31:0]             err_addr,
  output logic [7:0]              err_count
);

  localparam int          SEL_W       = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam logic [15:0] MAPPED_SPAN = 16'(N_SLAVES - 1);
  localparam logic [15:0] WINDOW_SPAN = 16'(RESERVED_SPAN);
  localparam logic [15:0] TIMEOUT_VAL = 16'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, RWAIT, WWAIT} state_t;

  state_t            state, next_state;
  logic [15:0]       region_off;
  logic [SEL_W-1:0]  sel, sel_q;
  logic              unmapped, unmapped_q;
  logic [31:0]       addr_q;
  logic [15:0]       wait_cnt;
  logic              accept, leave, slave_ready, timed_out;
  logic              log_err, load_rdata;
  logic [1:0]        err_kind;
  logic [31:0]       rdata_next;
  logic [31:0]       slave_rdata [N_SLAVES];
  logic              unused_wdata;

  // Slaves take write data straight from the CPU port.
  assign unused_wdata = ^mem_wdata;

  // Offset from the window base; addresses below the base wrap high and fall to slave 0.
  always_comb begin
    region_off = mem_addr[31:16] - BASE_REGION;
    sel        = '0;
    unmapped   = 1'b0;
    s_cs       = '0;
    if (region_off < MAPPED_SPAN) sel = SEL_W'(region_off + 16'd1);
    else if (region_off < WINDOW_SPAN) unmapped = 1'b1;
    if (!unmapped) s_cs[sel] = 1'b1;
  end

  always_comb begin
    for (int i = 0; i < N_SLAVES; i++) slave_rdata[i] = s_rdata[32*i +: 32];
  end

  assign accept      = (state == IDLE) && ((|mem_wmask) || mem_rstrb);
  assign slave_ready = ~s_busy[sel_q];
  assign timed_out   = (wait_cnt == TIMEOUT_VAL);
  assign leave       = (state != IDLE) && (unmapped_q || slave_ready || timed_out);
  assign mem_rbusy   = (state == RWAIT);
  assign mem_wbusy   = (state == WWAIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // A write beats a simultaneous read strobe.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (|mem_wmask)     next_state = WWAIT;
        else if (mem_rstrb) next_state = RWAIT;
      end
      RWAIT, WWAIT: if (leave) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    s_rd       = '0;
    s_wr       = '0;
    s_wmask    = '0;
    log_err    = 1'b0;
    err_kind   = 2'b00;
    load_rdata = 1'b0;
    rdata_next = mem_rdata;
    if (state == IDLE) begin
      if (|mem_wmask)     s_wr = s_cs;
      else if (mem_rstrb) s_rd = s_cs;
    end else if (leave) begin
      if (unmapped_q) begin
        log_err  = 1'b1;
        err_kind = 2'b01;
      end else if (!slave_ready) begin
        log_err  = 1'b1;
        err_kind = 2'b10;
      end
      if (state == RWAIT) begin
        load_rdata = 1'b1;
        rdata_next = log_err ? ERR_DATA : slave_rdata[sel_q];
      end
    end
    for (int i = 0; i < N_SLAVES; i++) s_wmask[4*i +: 4] = s_wr[i] ? mem_wmask : 4'b0000;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_q      <= '0;
      unmapped_q <= 1'b0;
      addr_q     <= '0;
      wait_cnt   <= '0;
      mem_rdata  <= '0;
    end else begin
      if (accept) begin
        sel_q      <= sel;
        unmapped_q <= unmapped;
        addr_q     <= mem_addr;
      end
      if (state == IDLE || leave) wait_cnt <= '0;
      else                        wait_cnt <= wait_cnt + 16'd1;
      if (load_rdata) mem_rdata <= rdata_next;
    end
  end

  // A new error wins over a same-cycle clear; otherwise the first error sticks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_err   <= 1'b0;
      err_code  <= 2'b00;
      err_addr  <= '0;
      err_count <= '0;
    end else if (log_err) begin
      if (err_count != 8'hFF) err_count <= err_count + 8'd1;
      if (!bus_err || err_clr) begin
        bus_err  <= 1'b1;
        err_code <= err_kind;
        err_addr <= addr_q;
      end
    end else if (err_clr) begin
      bus_err  <= 1'b0;
      err_code <= 2'b00;
    end
  end

endmodule
